// File: rtl/uart_fifo.sv
// uart_fifo: full-duplex UART with first-word fall-through RX and TX FIFOs.
// Parity is compiled in only when UART_FIFO_PARITY_EN is defined; without it
// frames are start + DATA_BITS + stop and RxParityError is tied low.

// Synchronous FIFO; the parent qualifies wr_en/rd_en against full/empty.
module uart_fifo_buf #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   // Pointer and occupancy update; simultaneous push and pop keep the count.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset because the head is masked when empty.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_data;
   end

   assign empty   = (count_q == '0);
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign count   = count_q;
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
endmodule

module uart_fifo #(
   parameter int unsigned BAUD_DIV   = 217,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                          Clk,
   input  logic                          ResetN,
   input  logic                          Rx,
   input  logic                          RxEnable,
   input  logic                          RxUnload,
   output logic [DATA_BITS-1:0]          RxData,
   output logic                          RxValid,
   output logic [$clog2(FIFO_DEPTH):0]   RxCount,
   output logic                          RxFrameError,
   output logic                          RxOverflow,
   output logic                          RxParityError,
   input  logic                          ErrClear,
   output logic                          Tx,
   input  logic [DATA_BITS-1:0]          TxData,
   input  logic                          TxSend,
   output logic                          TxFull,
   output logic                          TxEmpty,
   input  logic                          ParityOdd
);
   localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned CNT_W = $clog2(STOP_BITS * BAUD_DIV) + 1;
   localparam int unsigned BIT_W = $clog2(DATA_BITS);

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
`ifdef UART_FIFO_PARITY_EN
      RX_PARITY,
`endif
      RX_STOP
   } rx_state_t;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
`ifdef UART_FIFO_PARITY_EN
      TX_PARITY,
`endif
      TX_STOP
   } tx_state_t;

   // ---------------- receive path ----------------
   logic                 rx_meta_q, rx_sync_q, rx_prev_q;
   rx_state_t            rx_state_q, rx_state_d;
   logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
   logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
   logic                 rx_push, rx_ferr_set;
   logic                 rx_ferr_q, rx_ferr_d, rx_ovf_q, rx_ovf_d;
   logic                 rx_wr, rx_rd, rx_empty, rx_full, rx_ovf_set;
`ifdef UART_FIFO_PARITY_EN
   logic                 rx_perr_set, rx_perr_q, rx_perr_d;
`endif

   // Two-flop synchroniser plus one delayed copy for falling-edge detection.
   // Requiring the previous sample high also keeps RX from re-arming on a
   // line held low after a bad stop bit.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= Rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   // RX next-state: half-bit wait to centre, then one sample per BAUD_DIV.
   always_comb begin
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q + 1'b1;
      rx_bit_d    = rx_bit_q;
      rx_shift_d  = rx_shift_q;
      rx_push     = 1'b0;
      rx_ferr_set = 1'b0;
`ifdef UART_FIFO_PARITY_EN
      rx_perr_set = 1'b0;
`endif
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (!rx_sync_q && rx_prev_q) rx_state_d = RX_START;
         end
         RX_START: begin
            if (rx_cnt_q == CNT_W'(BAUD_DIV/2 - 1)) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == CNT_W'(BAUD_DIV - 1)) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
               if (rx_bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_FIFO_PARITY_EN
                  rx_state_d = RX_PARITY;
`else
                  rx_state_d = RX_STOP;
`endif
               end else begin
                  rx_bit_d = rx_bit_q + 1'b1;
               end
            end
         end
`ifdef UART_FIFO_PARITY_EN
         RX_PARITY: begin
            if (rx_cnt_q == CNT_W'(BAUD_DIV - 1)) begin
               rx_cnt_d    = '0;
               rx_perr_set = ((^rx_shift_q) ^ rx_sync_q) != ParityOdd;
               rx_state_d  = RX_STOP;
            end
         end
`endif
         RX_STOP: begin
            if (rx_cnt_q == CNT_W'(BAUD_DIV - 1)) begin
               rx_cnt_d    = '0;
               rx_push     = rx_sync_q;
               rx_ferr_set = !rx_sync_q;
               rx_state_d  = RX_IDLE;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
      // Disabling the receiver drops any frame in flight, including its push.
      if (!RxEnable) begin
         rx_state_d  = RX_IDLE;
         rx_cnt_d    = '0;
         rx_push     = 1'b0;
         rx_ferr_set = 1'b0;
`ifdef UART_FIFO_PARITY_EN
         rx_perr_set = 1'b0;
`endif
      end
   end

   // RX state registers.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
      end
   end

   // A full FIFO still accepts a push when a pop frees a slot the same cycle.
   assign rx_rd      = RxUnload && !rx_empty;
   assign rx_wr      = rx_push && (!rx_full || rx_rd);
   assign rx_ovf_set = rx_push && rx_full && !rx_rd;

   uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk     (Clk),
      .rst_n   (ResetN),
      .wr_en   (rx_wr),
      .wr_data (rx_shift_q),
      .rd_en   (rx_rd),
      .rd_data (RxData),
      .count   (RxCount),
      .empty   (rx_empty),
      .full    (rx_full)
   );

   // Sticky error flags: a set event outranks ErrClear in the same cycle.
   always_comb begin
      rx_ferr_d = rx_ferr_set ? 1'b1 : (ErrClear ? 1'b0 : rx_ferr_q);
      rx_ovf_d  = rx_ovf_set  ? 1'b1 : (ErrClear ? 1'b0 : rx_ovf_q);
`ifdef UART_FIFO_PARITY_EN
      rx_perr_d = rx_perr_set ? 1'b1 : (ErrClear ? 1'b0 : rx_perr_q);
`endif
   end

   // Error flag registers.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         rx_ferr_q <= 1'b0;
         rx_ovf_q  <= 1'b0;
`ifdef UART_FIFO_PARITY_EN
         rx_perr_q <= 1'b0;
`endif
      end else begin
         rx_ferr_q <= rx_ferr_d;
         rx_ovf_q  <= rx_ovf_d;
`ifdef UART_FIFO_PARITY_EN
         rx_perr_q <= rx_perr_d;
`endif
      end
   end

   assign RxValid      = !rx_empty;
   assign RxFrameError = rx_ferr_q;
   assign RxOverflow   = rx_ovf_q;
`ifdef UART_FIFO_PARITY_EN
   assign RxParityError = rx_perr_q;
`else
   logic unused_parity_odd;
   assign unused_parity_odd = ParityOdd;
   assign RxParityError     = 1'b0;
`endif

   // ---------------- transmit path ----------------
   tx_state_t            tx_state_q, tx_state_d;
   logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
   logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d, tx_head;
   logic                 tx_q, tx_d, tx_load, tx_rd, tx_wr, tx_fifo_empty, tx_fifo_full;
   logic [CW-1:0]        unused_tx_count;
`ifdef UART_FIFO_PARITY_EN
   logic                 tx_par_q, tx_par_d;
`endif

   assign tx_wr = TxSend && !tx_fifo_full;

   uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk     (Clk),
      .rst_n   (ResetN),
      .wr_en   (tx_wr),
      .wr_data (TxData),
      .rd_en   (tx_rd),
      .rd_data (tx_head),
      .count   (unused_tx_count),
      .empty   (tx_fifo_empty),
      .full    (tx_fifo_full)
   );

   // TX next-state; a waiting word is loaded straight out of STOP so frames
   // run back to back. The line is registered from the current state, which
   // delays every bit by one clock but keeps each bit BAUD_DIV clocks wide.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + 1'b1;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_load    = 1'b0;
`ifdef UART_FIFO_PARITY_EN
      tx_par_d   = tx_par_q;
`endif
      case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d = '0;
            tx_load  = !tx_fifo_empty;
         end
         TX_START: begin
            if (tx_cnt_q == CNT_W'(BAUD_DIV - 1)) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = TX_DATA;
            end
         end
         TX_DATA: begin
            if (tx_cnt_q == CNT_W'(BAUD_DIV - 1)) begin
               tx_cnt_d   = '0;
               tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
               if (tx_bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_FIFO_PARITY_EN
                  tx_state_d = TX_PARITY;
`else
                  tx_state_d = TX_STOP;
`endif
               end else begin
                  tx_bit_d = tx_bit_q + 1'b1;
               end
            end
         end
`ifdef UART_FIFO_PARITY_EN
         TX_PARITY: begin
            if (tx_cnt_q == CNT_W'(BAUD_DIV - 1)) begin
               tx_cnt_d   = '0;
               tx_state_d = TX_STOP;
            end
         end
`endif
         TX_STOP: begin
            if (tx_cnt_q == CNT_W'(STOP_BITS * BAUD_DIV - 1)) begin
               tx_cnt_d   = '0;
               tx_state_d = TX_IDLE;
               tx_load    = !tx_fifo_empty;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
      tx_rd = tx_load;
      if (tx_load) begin
         tx_shift_d = tx_head;
         tx_cnt_d   = '0;
         tx_state_d = TX_START;
`ifdef UART_FIFO_PARITY_EN
         tx_par_d   = (^tx_head) ^ ParityOdd;
`endif
      end
      case (tx_state_q)
         TX_START: tx_d = 1'b0;
         TX_DATA:  tx_d = tx_shift_q[0];
`ifdef UART_FIFO_PARITY_EN
         TX_PARITY: tx_d = tx_par_q;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   // TX state and line registers.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_q       <= 1'b1;
`ifdef UART_FIFO_PARITY_EN
         tx_par_q   <= 1'b0;
`endif
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_q       <= tx_d;
`ifdef UART_FIFO_PARITY_EN
         tx_par_q   <= tx_par_d;
`endif
      end
   end

   assign Tx      = tx_q;
   assign TxFull  = tx_fifo_full;
   assign TxEmpty = tx_fifo_empty && (tx_state_q == TX_IDLE);
endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo at BAUD_DIV=8, DATA_BITS=8, FIFO_DEPTH=4.
// Parity checks are added when UART_FIFO_PARITY_EN is defined.
module tb_uart_fifo;
   logic       Clk = 1'b0;
   logic       ResetN, RxEnable, RxUnload, ErrClear, TxSend, ParityOdd;
   logic [7:0] TxData, RxData;
   logic [2:0] RxCount;
   logic       RxValid, RxFrameError, RxOverflow, RxParityError;
   logic       Tx, TxFull, TxEmpty;
   logic       rx_drv, loop_en, rx_in;
   int         n_checks = 0;
   int         n_errors = 0;

   assign rx_in = loop_en ? Tx : rx_drv;

   uart_fifo #(.BAUD_DIV(8), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
      .Clk           (Clk),
      .ResetN        (ResetN),
      .Rx            (rx_in),
      .RxEnable      (RxEnable),
      .RxUnload      (RxUnload),
      .RxData        (RxData),
      .RxValid       (RxValid),
      .RxCount       (RxCount),
      .RxFrameError  (RxFrameError),
      .RxOverflow    (RxOverflow),
      .RxParityError (RxParityError),
      .ErrClear      (ErrClear),
      .Tx            (Tx),
      .TxData        (TxData),
      .TxSend        (TxSend),
      .TxFull        (TxFull),
      .TxEmpty       (TxEmpty),
      .ParityOdd     (ParityOdd)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic pulse_unload();
      RxUnload = 1'b1; clk_n(1); RxUnload = 1'b0;
   endtask

   task automatic pulse_clear();
      ErrClear = 1'b1; clk_n(1); ErrClear = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] d);
      TxData = d; TxSend = 1'b1; clk_n(1); TxSend = 1'b0;
   endtask

   // Drives one frame on Rx, 8 clocks per bit, followed by one idle bit time.
   task automatic rx_frame(input logic [7:0] data, input logic stop, input logic par_bad);
      rx_drv = 1'b0; clk_n(8);
      for (int i = 0; i < 8; i++) begin
         rx_drv = data[i]; clk_n(8);
      end
`ifdef UART_FIFO_PARITY_EN
      rx_drv = (^data) ^ ParityOdd ^ par_bad; clk_n(8);
`endif
      rx_drv = stop; clk_n(8);
      rx_drv = 1'b1; clk_n(8);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic tx_bits [8];
      tx_bits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};   // 0xA5 LSB first
      ResetN = 1'b1; RxEnable = 1'b1; RxUnload = 1'b0; ErrClear = 1'b0;
      TxSend = 1'b0; TxData = '0; ParityOdd = 1'b0; rx_drv = 1'b1; loop_en = 1'b0;
      #2 ResetN = 1'b0;
      #1;
      check("rst_tx", Tx, 1);
      check("rst_rxvalid", RxValid, 0);
      check("rst_rxcount", RxCount, 0);
      check("rst_rxdata", RxData, 0);
      check("rst_flags", {RxFrameError, RxOverflow, RxParityError}, 0);
      check("rst_txfull", TxFull, 0);
      check("rst_txempty", TxEmpty, 1);
      clk_n(3);
      ResetN = 1'b1;
      clk_n(2);

      // Single word 0xA5 on Tx.
      send_word(8'hA5);
      clk_n(1); check("tx_pre_start", Tx, 1);
      clk_n(1); check("tx_start", Tx, 0);
      check("tx_busy", TxEmpty, 0);
      clk_n(7); check("tx_start_hold", Tx, 0);
      for (int i = 0; i < 8; i++) begin
         clk_n(1); check($sformatf("tx_bit%0d", i), Tx, tx_bits[i]);
         clk_n(7); check($sformatf("tx_bit%0d_hold", i), Tx, tx_bits[i]);
      end
`ifdef UART_FIFO_PARITY_EN
      clk_n(1); check("tx_par_a5", Tx, 0);
      clk_n(7);
`endif
      clk_n(1); check("tx_stop", Tx, 1);
      check("tx_busy_stop", TxEmpty, 0);
      clk_n(7); check("tx_done_empty", TxEmpty, 1);
      check("tx_done_line", Tx, 1);

      // Loopback of three back-to-back words.
      loop_en = 1'b1;
      send_word(8'h00); send_word(8'hFF); send_word(8'h3C);
      for (int i = 0; i < 600 && RxCount != 3'd3; i++) clk_n(1);
      clk_n(20);
      check("loop_count", RxCount, 3);
      check("loop_d0", RxData, 8'h00); pulse_unload();
      check("loop_d1", RxData, 8'hFF); pulse_unload();
      check("loop_d2", RxData, 8'h3C); pulse_unload();
      check("loop_empty", RxValid, 0);
      check("loop_flags", {RxFrameError, RxOverflow, RxParityError}, 0);
      check("loop_txempty", TxEmpty, 1);
      loop_en = 1'b0;

      // Overflow: five frames into a four-deep FIFO.
      rx_frame(8'h11, 1'b1, 1'b0);
      rx_frame(8'h22, 1'b1, 1'b0);
      rx_frame(8'h33, 1'b1, 1'b0);
      rx_frame(8'h44, 1'b1, 1'b0);
      check("ovf_none_yet", RxOverflow, 0);
      rx_frame(8'h55, 1'b1, 1'b0);
      check("ovf_count", RxCount, 4);
      check("ovf_flag", RxOverflow, 1);
      check("ovf_head", RxData, 8'h11);
      pulse_unload();
      check("ovf_next", RxData, 8'h22);
      check("ovf_sticky", RxOverflow, 1);
      pulse_clear();
      check("ovf_cleared", RxOverflow, 0);
      pulse_unload(); check("ovf_d2", RxData, 8'h33);
      pulse_unload(); check("ovf_d3", RxData, 8'h44);
      pulse_unload();
      check("ovf_drained", RxCount, 0);
      pulse_unload();
      check("unload_empty_count", RxCount, 0);
      check("unload_empty_data", RxData, 0);

      // Stop bit low.
      rx_frame(8'h55, 1'b0, 1'b0);
      check("ferr_flag", RxFrameError, 1);
      check("ferr_count", RxCount, 0);
      pulse_clear();
      check("ferr_cleared", RxFrameError, 0);

      // Three-clock low glitch.
      rx_drv = 1'b0; clk_n(3); rx_drv = 1'b1; clk_n(40);
      check("glitch_count", RxCount, 0);
      check("glitch_flags", {RxFrameError, RxOverflow, RxParityError}, 0);

      // Good frame after errors, left in the FIFO.
      rx_frame(8'h5A, 1'b1, 1'b0);
      check("good_count", RxCount, 1);
      check("good_data", RxData, 8'h5A);

      // RxEnable dropped for one cycle during a 0xF0 frame.
      rx_drv = 1'b0; clk_n(20);
      RxEnable = 1'b0; clk_n(1); RxEnable = 1'b1;
      clk_n(19);
      rx_drv = 1'b1; clk_n(60);
      check("abort_count", RxCount, 1);
      check("abort_data", RxData, 8'h5A);
      check("abort_ferr", RxFrameError, 0);

      // Reset in the middle of a looped-back frame.
      loop_en = 1'b1;
      send_word(8'h00);
      clk_n(30);
      check("mid_tx_low", Tx, 0);
      ResetN = 1'b0; #1;
      check("mid_rst_tx", Tx, 1);
      check("mid_rst_count", RxCount, 0);
      check("mid_rst_data", RxData, 0);
      check("mid_rst_txempty", TxEmpty, 1);
      clk_n(2); ResetN = 1'b1;
      clk_n(120);
      check("mid_after_count", RxCount, 0);
      check("mid_after_tx", Tx, 1);
      check("mid_after_ferr", RxFrameError, 0);
      loop_en = 1'b0;

`ifdef UART_FIFO_PARITY_EN
      ParityOdd = 1'b0;
      send_word(8'h07);
      clk_n(1 + 8 + 64 + 1);
      check("par_tx_07", Tx, 1);
      clk_n(20);
      rx_frame(8'h07, 1'b1, 1'b1);
      check("par_err", RxParityError, 1);
      check("par_count", RxCount, 1);
      check("par_data", RxData, 8'h07);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
